// File: rtl/uart.sv
// 8N1 UART: independent transmitter and receiver with a 2-flop rxd synchronizer.
// Scan ports are placeholders that DFT insertion stitches; they carry no function here.
module uart #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_in0,
  input  logic       scan_in1,
  input  logic       scan_in2,
  input  logic       scan_in3,
  input  logic       scan_in4,
  input  logic       scan_enable,
  input  logic       test_mode,
  output logic       scan_out0,
  output logic       scan_out1,
  output logic       scan_out2,
  output logic       scan_out3,
  output logic       scan_out4,
  input  logic       rxd,
  output logic       txd,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_e;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             txd_q;
  logic             tx_ready_q;

  assign txd      = txd_q;
  assign tx_ready = tx_ready_q;

  // Transmitter: txd and tx_ready are registered so reset forces them high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            tx_state_q <= TX_START;
            tx_shift_q <= tx_data;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b0;
            tx_ready_q <= 1'b0;
          end
        end
        TX_START: begin
          tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          if (tx_cnt_q == BIT_END) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
          end
        end
        TX_DATA: begin
          tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
            end
          end
        end
        TX_STOP: begin
          tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          if (tx_cnt_q == BIT_END) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_ready_q <= 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_ferr_q;
  logic             rx_s1_q;
  logic             rx_s2_q;
  logic             rx_prev_q;

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;

  // Receiver: start edge, half-bit re-check, then centre sampling every bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q  <= '0;
            rx_data_q <= rx_shift_q;
            if (rx_s2_q) begin
              rx_valid_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_ferr_q  <= 1'b1;
              rx_state_q <= RX_WAIT_IDLE;
            end
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_s2_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart at 16 clocks per bit: frame shape, handshake timing,
// loopback reception, framing error, glitch rejection and mid-frame reset.
module tb_uart;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd_drv;
  logic       loop_en;
  logic       rxd;
  logic       txd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       so0, so1, so2, so3, so4;
  logic       scan_zero = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         scan_bad  = 0;
  logic [7:0] rx_log [0:63];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [0:4];

  always #5 clk = ~clk;

  assign rxd = loop_en ? txd : rxd_drv;

  uart #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_zero), .scan_in1(scan_zero), .scan_in2(scan_zero),
    .scan_in3(scan_zero), .scan_in4(scan_zero),
    .scan_enable(scan_zero), .test_mode(scan_zero),
    .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
    .rxd(rxd), .txd(txd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
  );

  // Cycle-level record of receiver pulses and scan outputs.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_log[valid_cnt % 64] = rx_data;
      valid_cnt = valid_cnt + 1;
    end
    if (rx_frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if ({so0, so1, so2, so3, so4} !== 5'b0) scan_bad = scan_bad + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Hand a byte to the transmitter and verify the whole 10-bit frame and tx_ready timing.
  task automatic tx_frame(input logic [7:0] data, input logic [9:0] frame);
    int n;
    int low_cnt;
    int bad;
    logic [9:0] seen;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 40 * C) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", 32'(n), 32'd0);
    tx_data  = data;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    low_cnt = 0;
    bad     = 0;
    seen    = '0;
    for (int j = 0; j < 10 * C; j++) begin
      @(negedge clk);
      if (tx_ready === 1'b0) low_cnt++;
      if (txd !== frame[j / C]) bad++;
      if (j % C == C / 2) seen[j / C] = txd;
    end
    check("tx_frame_bits", 32'(seen), 32'(frame));
    check("tx_bit_stable", 32'(bad), 32'd0);
    check("tx_ready_low_cycles", 32'(low_cnt), 32'(10 * C));
  endtask

  // Drive a raw frame on rxd from the bench; stop bit value is selectable.
  task automatic rx_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd_drv = bits[b];
      repeat (C) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    int v0;
    int f0;
    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h3C, frame: 10'h278};
    vecs[2] = '{data: 8'hC3, frame: 10'h386};
    vecs[3] = '{data: 8'h00, frame: 10'h200};
    vecs[4] = '{data: 8'hFF, frame: 10'h3FE};

    reset    = 1'b0;
    rxd_drv  = 1'b1;
    loop_en  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_scan_out", 32'({so0, so1, so2, so3, so4}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back loopback frames, including the 0x3C/0xC3 pair.
    loop_en = 1'b1;
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) begin
      tx_frame(vecs[i].data, vecs[i].frame);
      check("loop_rx_count", 32'(valid_cnt - v0), 32'(i + 1));
      check("loop_rx_data", 32'(rx_log[(v0 + i) % 64]), 32'(vecs[i].data));
    end
    check("loop_no_frame_err", 32'(ferr_cnt), 32'd0);
    repeat (2 * C) @(negedge clk);

    // Stop bit driven low: one framing-error pulse, no valid, data still captured.
    loop_en = 1'b0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx_frame(8'h55, 1'b0);
    repeat (2 * C) @(negedge clk);
    check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_rx_data", 32'(rx_data), 32'h55);

    // Short low glitch is rejected, then a real frame is received.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_rx_data_held", 32'(rx_data), 32'h55);
    rx_frame(8'h81, 1'b1);
    repeat (2 * C) @(negedge clk);
    check("post_glitch_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_glitch_data", 32'(rx_data), 32'h81);
    check("post_glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Reset during data bit 4 of a transmit; no partial frame afterwards.
    loop_en = 1'b1;
    v0 = valid_cnt;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (5 * C + C / 2) @(negedge clk);
    check("abort_pre_txd", 32'(txd), 32'd0);
    check("abort_pre_ready", 32'(tx_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_txd_async", 32'(txd), 32'd1);
    check("abort_ready_async", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12 * C) @(negedge clk);
    check("abort_txd_idle", 32'(txd), 32'd1);
    check("abort_no_rx_valid", 32'(valid_cnt - v0), 32'd0);
    tx_frame(8'h0F, 10'h21E);
    repeat (C) @(negedge clk);
    check("after_abort_rx_count", 32'(valid_cnt - v0), 32'd1);
    check("after_abort_rx_data", 32'(rx_data), 32'h0F);
    check("scan_out_always_zero", 32'(scan_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
